// File: rtl/vga_pixel_buffer.sv
// Ping-pong word buffers, 2 bpp pixel unpack, palette lookup and underrun tracking for the VGA scan-out path.
// Optional macro VGA_PALETTE_EN turns the fixed greyscale palette into four writable RGB332 registers.
module vga_pixel_buffer #(
    parameter int RES_X        = 640,
    parameter int RES_Y        = 480,
    parameter int PIX_PER_WORD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] row,
    input  logic [10:0] col,
    input  logic [31:0] bus_in,
    input  logic        buf_sel,
    input  logic        buf0_we,
    input  logic        buf1_we,
    input  logic        pal_we,
    input  logic [1:0]  pal_idx,
    input  logic [7:0]  pal_data,
    input  logic        underrun_clr,
    output logic [7:0]  rgb,
    output logic        pix_valid,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);

    localparam int          IDX_W   = $clog2(PIX_PER_WORD);
    localparam logic [10:0] RES_X_L = 11'(RES_X);
    localparam logic [10:0] RES_Y_L = 11'(RES_Y);
    localparam logic [7:0]  PAL0    = 8'h00;
    localparam logic [7:0]  PAL1    = 8'h49;
    localparam logic [7:0]  PAL2    = 8'h92;
    localparam logic [7:0]  PAL3    = 8'hFF;

    logic [31:0] buf0_q, buf0_d;
    logic [31:0] buf1_q, buf1_d;
    logic        fresh0_q, fresh0_d;
    logic        fresh1_q, fresh1_d;
    logic        sel_q, sel_d;

    logic [1:0]  pix_s1_q, pix_s1_d;
    logic        vis_s1_q, vis_s1_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d;

    logic        underrun_q, underrun_d;
    logic [7:0]  underrun_cnt_q, underrun_cnt_d;

    logic             visible;
    logic [IDX_W-1:0] pix_idx;
    logic [31:0]      disp_word;
    logic             disp_fresh;
    logic             underrun_event;
    logic [7:0]       pal_value;

    // Scan-position decode and display-side word selection.
    always_comb begin
        visible        = (col < RES_X_L) && (row < RES_Y_L);
        pix_idx        = col[IDX_W-1:0];
        disp_word      = buf_sel ? buf0_q : buf1_q;
        disp_fresh     = buf_sel ? fresh0_q : fresh1_q;
        underrun_event = visible && (pix_idx == '0) && !disp_fresh;
    end

    // Buffer writes and fresh flags; a swap clears the new write target before any same-cycle write sets it.
    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        fresh0_d = fresh0_q;
        fresh1_d = fresh1_q;
        sel_d    = buf_sel;

        if (buf_sel != sel_q) begin
            if (buf_sel) begin
                fresh1_d = 1'b0;
            end else begin
                fresh0_d = 1'b0;
            end
        end

        if (buf0_we) begin
            buf0_d   = bus_in;
            fresh0_d = 1'b1;
        end else if (buf1_we) begin
            buf1_d   = bus_in;
            fresh1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0_q   <= '0;
            buf1_q   <= '0;
            fresh0_q <= 1'b0;
            fresh1_q <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            fresh0_q <= fresh0_d;
            fresh1_q <= fresh1_d;
            sel_q    <= sel_d;
        end
    end

`ifdef VGA_PALETTE_EN
    logic [7:0] pal_q [4];
    logic [7:0] pal_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pal_d[i] = pal_q[i];
        end
        if (pal_we) begin
            pal_d[pal_idx] = pal_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pal_q[0] <= PAL0;
            pal_q[1] <= PAL1;
            pal_q[2] <= PAL2;
            pal_q[3] <= PAL3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pal_q[i] <= pal_d[i];
            end
        end
    end

    // Lookup reads the registered entry, so a coincident write shows up one cycle later.
    always_comb begin
        pal_value = pal_q[pix_s1_q];
    end
`else
    logic unused_pal_inputs;

    always_comb begin
        unused_pal_inputs = ^{pal_we, pal_idx, pal_data};
        case (pix_s1_q)
            2'd0:    pal_value = PAL0;
            2'd1:    pal_value = PAL1;
            2'd2:    pal_value = PAL2;
            default: pal_value = PAL3;
        endcase
    end
`endif

    // Two-stage pixel pipeline: unpack/visibility, then palette lookup with blanking.
    always_comb begin
        pix_s1_d    = disp_word[{pix_idx, 1'b0} +: 2];
        vis_s1_d    = visible;
        rgb_d       = vis_s1_q ? pal_value : 8'h00;
        pix_valid_d = vis_s1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_s1_q    <= 2'b00;
            vis_s1_q    <= 1'b0;
            rgb_q       <= 8'h00;
            pix_valid_q <= 1'b0;
        end else begin
            pix_s1_q    <= pix_s1_d;
            vis_s1_q    <= vis_s1_d;
            rgb_q       <= rgb_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // Sticky flag and saturating count; a coincident event beats the clear and restarts the count at one.
    always_comb begin
        underrun_d     = underrun_q;
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_clr) begin
            underrun_d     = underrun_event;
            underrun_cnt_d = underrun_event ? 8'd1 : 8'd0;
        end else if (underrun_event) begin
            underrun_d = 1'b1;
            if (underrun_cnt_q != 8'hFF) begin
                underrun_cnt_d = underrun_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= 8'h00;
        end else begin
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign rgb          = rgb_q;
    assign pix_valid    = pix_valid_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_vga_pixel_buffer.sv
// Directed, scoreboard-based bench for vga_pixel_buffer; expected pixels are queued at drive time and popped two clocks later.
module tb_vga_pixel_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] row, col;
    logic [31:0] bus_in;
    logic        buf_sel, buf0_we, buf1_we;
    logic        pal_we;
    logic [1:0]  pal_idx;
    logic [7:0]  pal_data;
    logic        underrun_clr;
    logic [7:0]  rgb;
    logic        pix_valid;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    vga_pixel_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .bus_in       (bus_in),
        .buf_sel      (buf_sel),
        .buf0_we      (buf0_we),
        .buf1_we      (buf1_we),
        .pal_we       (pal_we),
        .pal_idx      (pal_idx),
        .pal_data     (pal_data),
        .underrun_clr (underrun_clr),
        .rgb          (rgb),
        .pix_valid    (pix_valid),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rgb;
        logic       valid;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;

    logic [31:0] m_buf0, m_buf1;
    logic        m_fr0, m_fr1, m_sel;
    logic [7:0]  m_pal [4];
    logic        m_ur;
    logic [7:0]  m_cnt;
    logic        ur_pend;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf0 = '0; m_buf1 = '0;
        m_fr0 = 1'b0; m_fr1 = 1'b0; m_sel = 1'b0;
        m_pal[0] = 8'h00; m_pal[1] = 8'h49; m_pal[2] = 8'h92; m_pal[3] = 8'hFF;
        m_ur = 1'b0; m_cnt = 8'h00;
        ur_pend = 1'b0;
        sb.delete();
    endtask

    // One clock: check what is due, drive new inputs, and advance the reference model.
    task automatic step(input logic [10:0] r, input logic [10:0] c, input logic bsel,
                        input logic w0, input logic w1, input logic [31:0] d,
                        input logic pw, input logic [1:0] pi, input logic [7:0] pd,
                        input logic clr);
        exp_t        e;
        logic        vis, fr, ev;
        logic [31:0] w;
        logic [1:0]  px;
        @(negedge clk);
        if (sb.size() == 2) begin
            e = sb.pop_front();
            chk("rgb", rgb, e.rgb);
            chk("pix_valid", {7'd0, pix_valid}, {7'd0, e.valid});
        end
        if (ur_pend) begin
            chk("underrun", {7'd0, underrun}, {7'd0, m_ur});
            chk("underrun_cnt", underrun_cnt, m_cnt);
        end
        row = r; col = c; buf_sel = bsel; buf0_we = w0; buf1_we = w1; bus_in = d;
        pal_we = pw; pal_idx = pi; pal_data = pd; underrun_clr = clr;
`ifdef VGA_PALETTE_EN
        if (pw) m_pal[pi] = pd;
`endif
        vis = (c < 11'd640) && (r < 11'd480);
        w   = bsel ? m_buf0 : m_buf1;
        fr  = bsel ? m_fr0 : m_fr1;
        px  = 2'(w >> (2 * int'(c[3:0])));
        e.rgb   = vis ? m_pal[px] : 8'h00;
        e.valid = vis;
        sb.push_back(e);
        ev = vis && (c[3:0] == 4'd0) && !fr;
        if (clr) begin
            m_ur  = ev;
            m_cnt = ev ? 8'd1 : 8'd0;
        end else if (ev) begin
            m_ur = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        if (bsel != m_sel) begin
            if (bsel) m_fr1 = 1'b0;
            else      m_fr0 = 1'b0;
        end
        if (w0) begin
            m_buf0 = d; m_fr0 = 1'b1;
        end else if (w1) begin
            m_buf1 = d; m_fr1 = 1'b1;
        end
        m_sel   = bsel;
        ur_pend = 1'b1;
        $display("step row=%0d col=%0d sel=%0b we=%0b%0b clr=%0b exp_rgb=0x%h", r, c, bsel, w0, w1, clr, e.rgb);
    endtask

    task automatic pix(input logic [10:0] r, input logic [10:0] c, input logic bsel);
        step(r, c, bsel, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        row = 11'd700; col = 11'd700; bus_in = '0; buf_sel = 1'b0;
        buf0_we = 1'b0; buf1_we = 1'b0; pal_we = 1'b0; pal_idx = 2'd0; pal_data = 8'h00;
        underrun_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", rgb, 8'h00);
        chk("reset_valid", {7'd0, pix_valid}, 8'd0);
        chk("reset_underrun", {7'd0, underrun}, 8'd0);
        chk("reset_cnt", underrun_cnt, 8'h00);
        reset = 1'b0;

        // Unwritten display word: every word boundary is an underrun, count saturates.
        for (int i = 0; i < 300; i++) pix(11'(i / 40), 11'((i % 40) * 16), 1'b0);
        step(11'd0, 11'd700, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 8'h00, 1'b1);
        pix(11'd0, 11'd700, 1'b0);
        step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 8'h00, 1'b1);
        step(11'd0, 11'd700, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 8'h00, 1'b1);

        // Greyscale ramp from buf0.
        step(11'd0, 11'd700, 1'b1, 1'b1, 1'b0, 32'hE4E4E4E4, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int c = 0; c < 16; c++) pix(11'd0, 11'(c), 1'b1);

        // Fill back buffer while front shows zeros, then swap.
        step(11'd1, 11'd700, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 8'h00, 1'b0);
        step(11'd1, 11'd700, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int c = 0; c < 16; c++) pix(11'd1, 11'(c), 1'b1);
        for (int c = 16; c < 32; c++) pix(11'd1, 11'(c), 1'b0);

        // Blanking region with a non-zero word.
        pix(11'd10, 11'd640, 1'b0);
        pix(11'd480, 11'd5, 1'b0);
        pix(11'd2047, 11'd2047, 1'b0);

        // Both strobes: only buf0 is written.
        step(11'd2, 11'd700, 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int c = 32; c < 36; c++) pix(11'd2, 11'(c), 1'b1);
        pix(11'd2, 11'd36, 1'b0);

        // Palette entry 2 rewritten, including a write that coincides with lookups of that entry.
        step(11'd3, 11'd700, 1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b1, 2'd2, 8'h1C, 1'b0);
        for (int c = 0; c < 4; c++) pix(11'd3, 11'(c), 1'b1);
        step(11'd3, 11'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd2, 8'hE0, 1'b0);
        for (int c = 5; c < 9; c++) pix(11'd3, 11'(c), 1'b1);

        // Mid-line reset while white is on the output.
        step(11'd4, 11'd700, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int c = 0; c < 6; c++) pix(11'd4, 11'(c), 1'b0);
        @(negedge clk);
        chk("prereset_rgb", rgb, 8'hFF);
        #2 reset = 1'b1;
        #1;
        chk("async_rgb", rgb, 8'h00);
        chk("async_valid", {7'd0, pix_valid}, 8'd0);
        chk("async_underrun", {7'd0, underrun}, 8'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) pix(11'd5, 11'(c), 1'b0);
        for (int c = 0; c < 4; c++) pix(11'd5, 11'(c), 1'b1);
        pix(11'd5, 11'd700, 1'b1);
        pix(11'd5, 11'd700, 1'b1);
        pix(11'd5, 11'd700, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
